uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART. It turns the asynchronous serial line into framed words and delivers them to the host.
- Generates the oversampled bit timing.
- Validates the start bit at mid-bit and samples data bits at bit centres.
- Checks the stop bit and buffers received words in a small FIFO with a valid/ready handshake.
- Sits between the pad-side rxd pin and the host register/bus interface.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, default oversampling and a
// constant-evaluable ceil(log2) helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r = 0;
        int unsigned v = 1;
        while (v < value) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [BIT_WIDTH-1:0]       push_data_i,
    input  logic                       pop_i,
    output logic [BIT_WIDTH-1:0]       rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [clog2(FIFO_DEPTH):0] count_o
);
    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);

    logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 wr_en, rd_en;

    assign full_o    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_en     = pop_i && !empty_o;
    assign wr_en     = push_i && (!full_o || rd_en);

    // Storage is cleared on reset so the head word reads 0 while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchroniser, oversampled tick generator, framing FSM and a
// receive FIFO with valid/ready delivery to the host.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter bit          START_BIT  = 1'b0,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DIV_WIDTH-1:0]       baud_div,
    input  logic                       rxd,
    input  logic                       clr_err,
    output logic [BIT_WIDTH-1:0]       rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overrun,
    output logic [clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned SCNT_W   = clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W   = clog2(BIT_WIDTH);
    localparam int unsigned HALF     = OVERSAMPLE / 2;
    localparam logic        IDLE_LVL = ~START_BIT;

    rx_state_e            state_q, state_d;
    logic                 sync1_q, rxd_s, rxd_d_q;
    logic [DIV_WIDTH-1:0] div_q, div_d, tick_cnt_q, tick_cnt_d;
    logic [SCNT_W-1:0]    s_cnt_q, s_cnt_d;
    logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic                 frame_err_q, overrun_q;
    logic                 tick, start_edge, push, pop, fifo_full, fifo_empty;
    logic                 frame_set, ovr_set;

    assign tick       = (state_q != IDLE) && (tick_cnt_q == div_q);
    assign start_edge = en && (rxd_d_q == IDLE_LVL) && (rxd_s == START_BIT);
    assign pop        = rx_valid && rx_ready;
    assign rx_valid   = !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        s_cnt_d    = s_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_set  = 1'b0;
        ovr_set    = 1'b0;

        if (state_q != IDLE) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                s_cnt_d    = '0;
                bit_cnt_d  = '0;
                if (start_edge) begin
                    state_d = START;
                    div_d   = baud_div;
                end
            end
            // Re-check the line at mid start bit to reject glitches.
            START: if (tick) begin
                if (s_cnt_q == SCNT_W'(HALF - 1)) begin
                    s_cnt_d    = '0;
                    tick_cnt_d = '0;
                    state_d    = (rxd_s == START_BIT) ? DATA : IDLE;
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            DATA: if (tick) begin
                if (s_cnt_q == SCNT_W'(OVERSAMPLE - 1)) begin
                    s_cnt_d = '0;
                    shift_d = {rxd_s, shift_q[BIT_WIDTH-1:1]};
                    if (bit_cnt_q == BCNT_W'(BIT_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            STOP: if (tick) begin
                if (s_cnt_q == SCNT_W'(OVERSAMPLE - 1)) begin
                    s_cnt_d = '0;
                    state_d = IDLE;
                    if (rxd_s == START_BIT) begin
                        frame_set = 1'b1;
                    end else if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disabling the receiver abandons the frame silently.
        if ((state_q != IDLE) && !en) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            s_cnt_d    = '0;
            bit_cnt_d  = '0;
            push       = 1'b0;
            frame_set  = 1'b0;
            ovr_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= IDLE_LVL;
            rxd_s       <= IDLE_LVL;
            rxd_d_q     <= IDLE_LVL;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            s_cnt_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rxd;
            rxd_s       <= sync1_q;
            rxd_d_q     <= rxd_s;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            s_cnt_q     <= s_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_set | (frame_err_q & ~clr_err);
            overrun_q   <= ovr_set | (overrun_q & ~clr_err);
        end
    end

    uart_rx_fifo #(
        .BIT_WIDTH  (BIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (shift_q),
        .pop_i       (pop),
        .rd_data_o   (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames driven bit by bit on rxd, host-side
// results compared against hand-computed values.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, rxd, clr_err, rx_ready;
    logic [15:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid, busy, frame_err, overrun;
    logic [2:0]  fifo_count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int rise_cyc = -1;
    int busy_cnt = 0;
    logic rxv_prev = 1'b0;

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_div   (baud_div),
        .rxd        (rxd),
        .clr_err    (clr_err),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the first rx_valid rise after rise_cyc is re-armed to -1.
    always @(negedge clk) begin
        if (rx_valid && !rxv_prev && rise_cyc < 0) rise_cyc = cyc;
        rxv_prev = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit, 8 data bits LSB-first, stop level; optional one-cycle rx_ready
    // pulse at drive index pop_at (index 0 = negedge of the start-bit fall).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int div, input int pop_at);
        int b;
        logic [9:0] lv;
        b  = 16 * (div + 1);
        lv = {stop, d, 1'b0};
        for (int k = 0; k < 10 * b; k++) begin
            @(negedge clk);
            rxd = lv[k / b];
            if (k == 0) t0 = cyc;
            if (pop_at >= 0) rx_ready = (k == pop_at);
        end
        if (pop_at >= 0) rx_ready = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; rxd = 1'b1; clr_err = 1'b0; rx_ready = 1'b0; baud_div = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single frame 0xA5, baud_div=0: stop sampled 155 clocks after the fall.
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 0, -1);
        check("a5_latency_window", (rise_cyc - t0 >= 139) && (rise_cyc - t0 <= 160), 1);
        check("a5_rx_valid", rx_valid, 1);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_frame_err", frame_err, 0);
        check("a5_count", fifo_count, 1);
        pop_one();
        check("a5_popped_valid", rx_valid, 0);
        check("a5_popped_count", fifo_count, 0);

        // Glitch: 4 clocks low is rejected at mid start bit.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        check("glitch_busy_low", busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_frame_err", frame_err, 0);
        check("glitch_overrun", overrun, 0);

        // Framing error, then held break produces no new frame.
        send_frame(8'h3C, 1'b0, 0, -1);
        check("ferr_set", frame_err, 1);
        check("ferr_count", fifo_count, 0);
        pulse_clr();
        check("ferr_cleared", frame_err, 0);
        busy_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("break_no_frame", busy_cnt, 0);
        check("break_frame_err", frame_err, 0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);

        // Overrun: five frames into a four-entry FIFO with no reads.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1);
        check("ovr_count", fifo_count, 4);
        check("ovr_flag", overrun, 1);
        check("ovr_frame_err", frame_err, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_drain_%0d", i), rx_data, i);
            pop_one();
        end
        check("ovr_drained", rx_valid, 0);
        pulse_clr();
        check("ovr_cleared", overrun, 0);

        // Full FIFO with a pop on the stop-sample cycle accepts the new word.
        send_frame(8'h11, 1'b1, 0, -1);
        send_frame(8'h22, 1'b1, 0, -1);
        send_frame(8'h33, 1'b1, 0, -1);
        send_frame(8'h44, 1'b1, 0, -1);
        check("full_count", fifo_count, 4);
        send_frame(8'h77, 1'b1, 0, 154);
        check("full_pop_overrun", overrun, 0);
        check("full_pop_count", fifo_count, 4);
        check("full_drain_0", rx_data, 8'h22); pop_one();
        check("full_drain_1", rx_data, 8'h33); pop_one();
        check("full_drain_2", rx_data, 8'h44); pop_one();
        check("full_drain_3", rx_data, 8'h77); pop_one();
        check("full_drained", fifo_count, 0);

        // Abort by dropping en in the middle of the data bits of 0xFF.
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_busy_before", busy, 1);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy_after", busy, 0);
        repeat (160) @(negedge clk);
        en = 1'b1;
        check("abort_count", fifo_count, 0);
        check("abort_frame_err", frame_err, 0);
        check("abort_overrun", overrun, 0);

        // Asynchronous reset mid-frame clears everything without a clock edge.
        send_frame(8'h33, 1'b1, 0, -1);
        check("pre_rst_count", fifo_count, 1);
        rxd = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_rx_valid", rx_valid, 0);
        check("arst_rx_data", rx_data, 0);
        check("arst_count", fifo_count, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rxd = 1'b1;
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Recovery frame at baud_div=3.
        baud_div = 16'd3;
        send_frame(8'h5A, 1'b1, 3, -1);
        check("div3_rx_valid", rx_valid, 1);
        check("div3_rx_data", rx_data, 8'h5A);
        check("div3_count", fifo_count, 1);
        check("div3_frame_err", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
